// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, clear-FSM encoding and depth helper for regfile_mp
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - bulk-clear sequencer: sweeps every entry to zero, one per cycle
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_active,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(depth_of(ADDR_W) - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        // The edge that zeroes the last entry also leaves the sweep.
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign clr_active = (state_q == CLEAR);
  assign clr_we     = (state_q == CLEAR);
  assign clr_addr   = cnt_q;
  assign busy       = (state_q == CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with zero register, write bypass and bulk clear
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     clear_req,
  output logic                     busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              clr_active;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [NUM_WR-1:0] wr_ok;

  regfile_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_active(clr_active),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we)
  );

  // A write port is live only outside the sweep and when not aimed at the hardwired zero entry.
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wr_ok[j] = wr_en[j] && !clr_active &&
                      !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0));
  end

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_ok[j]) begin
        mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem_q[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
            rv = wr_data[j*DATA_W +: DATA_W];
          end
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rv = '0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rv;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass and non-bypass instances)
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] rd_data_nb;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        clear_req;
  logic        busy;
  logic        busy_nb;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model[32];

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clear_req(clear_req),
    .busy     (busy)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_nb),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clear_req(clear_req),
    .busy     (busy_nb)
  );

  task automatic test_reset();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0; clear_req = 1'b0;
    rd_addr = {5'd31, 5'd5};
    for (int i = 0; i < 32; i++) model[i] = '0;
    #12;
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_err++; $display("FAIL rst_rd0: got %h expected %h", rd_data[31:0], 32'h0); end
    n_cmp++; if (rd_data[63:32] !== 32'h0) begin n_err++; $display("FAIL rst_rd1: got %h expected %h", rd_data[63:32], 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_err++; $display("FAIL post_rst_rd0: got %h expected %h", rd_data[31:0], 32'h0); end
    n_cmp++; if (rd_data[63:32] !== 32'h0) begin n_err++; $display("FAIL post_rst_rd1: got %h expected %h", rd_data[63:32], 32'h0); end
    n_cmp++; if (busy_nb !== 1'b0) begin n_err++; $display("FAIL post_rst_busy_nb: got %b expected 0", busy_nb); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'hDEADBEEF; rd_addr[4:0] = 5'd3;
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_bypass_same: got %h expected %h", rd_data[31:0], 32'hDEADBEEF); end
    n_cmp++; if (rd_data_nb[31:0] !== 32'h0) begin n_err++; $display("FAIL wr_nobypass_same: got %h expected %h", rd_data_nb[31:0], 32'h0); end
    @(negedge clk); wr_en = 2'b00; #1;
    model[3] = 32'hDEADBEEF;
    n_cmp++; if (rd_data[31:0] !== model[3]) begin n_err++; $display("FAIL wr_next: got %h expected %h", rd_data[31:0], model[3]); end
    n_cmp++; if (rd_data_nb[31:0] !== model[3]) begin n_err++; $display("FAIL wr_next_nb: got %h expected %h", rd_data_nb[31:0], model[3]); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2222, 32'h1111}; rd_addr = {5'd3, 5'd7};
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h2222) begin n_err++; $display("FAIL coll_bypass: got %h expected %h", rd_data[31:0], 32'h2222); end
    n_cmp++; if (rd_data_nb[31:0] !== 32'h0) begin n_err++; $display("FAIL coll_nobypass_same: got %h expected %h", rd_data_nb[31:0], 32'h0); end
    n_cmp++; if (rd_data[63:32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL coll_other_port: got %h expected %h", rd_data[63:32], 32'hDEADBEEF); end
    @(negedge clk); wr_en = 2'b00; #1;
    model[7] = 32'h2222;
    n_cmp++; if (rd_data[31:0] !== model[7]) begin n_err++; $display("FAIL coll_next: got %h expected %h", rd_data[31:0], model[7]); end
    n_cmp++; if (rd_data_nb[31:0] !== model[7]) begin n_err++; $display("FAIL coll_next_nb: got %h expected %h", rd_data_nb[31:0], model[7]); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wr_en = 2'b10; wr_addr = {5'd0, 5'd3}; wr_data = {32'hFFFF_FFFF, 32'h0}; rd_addr = {5'd0, 5'd0};
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_err++; $display("FAIL zero_same_rd0: got %h expected %h", rd_data[31:0], 32'h0); end
    n_cmp++; if (rd_data[63:32] !== 32'h0) begin n_err++; $display("FAIL zero_same_rd1: got %h expected %h", rd_data[63:32], 32'h0); end
    @(negedge clk); wr_en = 2'b00; #1;
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_err++; $display("FAIL zero_next: got %h expected %h", rd_data[31:0], 32'h0); end
    n_cmp++; if (rd_data_nb[31:0] !== 32'h0) begin n_err++; $display("FAIL zero_next_nb: got %h expected %h", rd_data_nb[31:0], 32'h0); end
  endtask

  task automatic test_clear_sweep();
    exp_t e;
    int   busy_cycles;
    int   guard;
    for (int i = 1; i < 32; i += 2) begin
      @(negedge clk);
      wr_en   = (i + 1 < 32) ? 2'b11 : 2'b01;
      wr_addr = {5'(i + 1), 5'(i)};
      wr_data = {32'(i + 1), 32'(i)};
      model[i] = 32'(i);
      if (i + 1 < 32) model[i + 1] = 32'(i + 1);
    end
    @(negedge clk); wr_en = 2'b00;
    for (int a = 1; a < 32; a++) sb_q.push_back('{addr: 5'(a), exp: model[a]});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk); rd_addr[4:0] = e.addr; #1;
      n_cmp++; if (rd_data[31:0] !== e.exp) begin n_err++; $display("FAIL fill_rd addr %0d: got %h expected %h", e.addr, rd_data[31:0], e.exp); end
    end

    @(negedge clk);
    clear_req = 1'b1; wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'hAB;
    model[9] = 32'hAB;
    @(negedge clk);
    clear_req = 1'b0;
    wr_en = 2'b01; wr_addr[4:0] = 5'd4; wr_data[31:0] = 32'h55;
    rd_addr = {5'd9, 5'd4};
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clr_busy_rise: got %b expected 1", busy); end
    n_cmp++; if (rd_data[31:0] !== model[4]) begin n_err++; $display("FAIL clr_no_bypass: got %h expected %h", rd_data[31:0], model[4]); end
    n_cmp++; if (rd_data[63:32] !== model[9]) begin n_err++; $display("FAIL clr_same_cycle_write: got %h expected %h", rd_data[63:32], model[9]); end
    busy_cycles = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      busy_cycles++;
      guard++;
      @(negedge clk); wr_en = 2'b00; #1;
    end
    n_cmp++; if (busy_cycles != 32) begin n_err++; $display("FAIL clr_busy_len: got %0d expected %0d", busy_cycles, 32); end
    n_cmp++; if (busy_nb !== 1'b0) begin n_err++; $display("FAIL clr_busy_nb_fall: got %b expected 0", busy_nb); end

    for (int a = 0; a < 32; a++) begin
      model[a] = '0;
      sb_q.push_back('{addr: 5'(a), exp: model[a]});
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk); rd_addr = {e.addr, e.addr}; #1;
      n_cmp++; if (rd_data[63:32] !== e.exp) begin n_err++; $display("FAIL clr_rd addr %0d: got %h expected %h", e.addr, rd_data[63:32], e.exp); end
      n_cmp++; if (rd_data_nb[31:0] !== e.exp) begin n_err++; $display("FAIL clr_rd_nb addr %0d: got %h expected %h", e.addr, rd_data_nb[31:0], e.exp); end
    end
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd30, 5'd25}; wr_data = {32'h3030, 32'h2525};
    @(negedge clk);
    wr_en = 2'b00; clear_req = 1'b1; rd_addr = {5'd30, 5'd25};
    @(negedge clk);
    clear_req = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    n_cmp++; if (rd_data[31:0] !== 32'h2525) begin n_err++; $display("FAIL mid_unswept: got %h expected %h", rd_data[31:0], 32'h2525); end
    #1; rst = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_err++; $display("FAIL mid_rst_rd25: got %h expected %h", rd_data[31:0], 32'h0); end
    n_cmp++; if (rd_data_nb[63:32] !== 32'h0) begin n_err++; $display("FAIL mid_rst_rd30_nb: got %h expected %h", rd_data_nb[63:32], 32'h0); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd12; wr_data[31:0] = 32'h1234; rd_addr[4:0] = 5'd12;
    @(negedge clk); wr_en = 2'b00; #1;
    n_cmp++; if (rd_data[31:0] !== 32'h1234) begin n_err++; $display("FAIL post_mid_write: got %h expected %h", rd_data[31:0], 32'h1234); end
    n_cmp++; if (rd_data_nb[31:0] !== 32'h1234) begin n_err++; $display("FAIL post_mid_write_nb: got %h expected %h", rd_data_nb[31:0], 32'h1234); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_mid_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_zero_reg();
    test_clear_sweep();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the next generation of the CPU's 2-read/1-write register file. Configurable width, depth, read-port count and write-port count. Adds optional hardwired zero register, write-to-read bypass, and a sequenced bulk-clear engine with a busy flag. Sits in the decode stage and feeds the ALU operands; multiple write ports serve future dual-issue writeback.

Parameters:
DATA_W, 32, data width of each entry
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 2, number of write ports (>=1)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  write addresses
wr_data  in  NUM_WR*DATA_W  write data
clear_req  in  1  single-cycle request to zero every entry
busy  out  1  clear sequence in progress

Behaviour:
- Reset (rst=0, async): all entries = 0; FSM = IDLE; clear counter = 0; busy = 0. rd_data then reads 0 combinationally.
- Reads are combinational, zero latency: rd_data[k] = entry[rd_addr[k]].
- If ZERO_REG=1 and rd_addr[k]=0, rd_data[k]=0, with or without bypass.
- Writes commit on the rising clk edge when wr_en[j]=1 and the FSM is in IDLE.
- If ZERO_REG=1, writes to address 0 are dropped.
- Several ports writing the same address in one cycle: the highest-index port wins. Other addresses commit independently.
- Bypass (BYPASS=1, IDLE only): if any enabled, non-dropped write port matches rd_addr[k] in the same cycle, rd_data[k] = that port's wr_data (highest index wins). Otherwise array contents.
- With BYPASS=0, the new value is visible in the cycle after the write edge.
- Clear FSM, states IDLE and CLEAR:
  - IDLE with clear_req=1: the next edge enters CLEAR with counter = 0 and busy = 1 (registered).
  - CLEAR: each edge writes 0 to entry[counter] and increments counter.
  - At counter = DEPTH-1 the edge clears the last entry and returns to IDLE; busy = 0 from that edge.
  - busy is therefore high for exactly DEPTH cycles.
- During CLEAR:
  - All wr_en are ignored and the writes are lost; no bypass.
  - Reads return current array contents. Entries not yet swept keep old values; the entry being cleared this cycle still shows its old value.
  - clear_req is ignored.
- A write and clear_req in the same IDLE cycle: the write commits, then the clear sweep later zeroes it.
- Counter wraps only by the FSM exit; it is ADDR_W bits wide.
- Reset mid-CLEAR: immediate async clear of all entries; FSM = IDLE; busy = 0; no resumption.

Decomposition:
- Shared header/package regfile_pkg: default DATA_W/ADDR_W, FSM state encodings (IDLE=1'b0, CLEAR=1'b1), and a DEPTH derivation macro/function.
- One natural sub-module: regfile_clear_seq, holding the FSM, counter and busy. It outputs clr_active, clr_addr and clr_we to the array.
- Array write-port priority, zero-register masking and bypass muxes stay in regfile_mp using generate loops over NUM_RD/NUM_WR.

Test Plan:
- Reset then read: rst=0 then 1; rd_addr0=5, rd_addr1=31 -> rd_data0=0, rd_data1=0, busy=0.
- Basic write/read: wr_en=2'b01, wr_addr0=3, wr_data0=32'hDEADBEEF. Next cycle, rd_addr0=3 -> 32'hDEADBEEF. Same cycle with BYPASS=1 -> 32'hDEADBEEF. With BYPASS=0, the same cycle returns the old value 0.
- Write collision: wr_en=2'b11, both to addr 7, data0=32'h1111, data1=32'h2222 -> entry 7 = 32'h2222. Bypassed read in the same cycle = 32'h2222.
- Zero register: write 32'hFFFF_FFFF to addr 0 on port 1 -> rd_data for addr 0 = 0 in the same cycle and the next cycle.
- Clear sweep: fill entries 1..31 with their index. Pulse clear_req, with a write to addr 9 = 32'hAB in the same cycle.
  - busy high for 32 cycles.
  - A write to addr 4 = 32'h55 during busy is dropped.
  - After busy falls, all reads = 0, including addr 9.
- Reset mid-clear: assert rst=0 at cycle 10 of the sweep -> busy=0 immediately, all entries = 0. Subsequent writes work normally.
